// File: rtl/ecc_point_unit_pkg.sv
// Shared types and encodings for the elliptic-curve point unit and its
// modular-inverse helper.
package ecc_point_unit_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CLASSIFY,
    INV_START,
    INV_WAIT,
    LAMBDA,
    XR,
    YR,
    FINISH
  } state_t;

  typedef enum logic {
    INV_IDLE,
    INV_RUN
  } inv_state_t;

  localparam logic MODE_DBL = 1'b0;
  localparam logic MODE_ADD = 1'b1;

endpackage

// File: rtl/ecc_point_unit_mod_inv.sv
// Modular inverse x^-1 mod p (p odd) by binary extended Euclid, one
// reduction step per clock; failure when gcd(x, p) != 1.
module mod_inv
  import ecc_point_unit_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] p,
  output logic [WIDTH-1:0] x_inv,
  output logic             done,
  output logic             failure
);

  localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

  inv_state_t       state_reg, state_next;
  logic [WIDTH-1:0] u_reg, v_reg, x1_reg, x2_reg, p_reg, inv_reg;
  logic             done_reg, fail_reg;
  logic             load, run, terminal;

  // Invariants: x1*x == u and x2*x == v (mod p). Both odd halves sum to (a+m)/2.
  function automatic logic [WIDTH-1:0] half_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] m);
    return a[0] ? (a >> 1) + (m >> 1) + ONE : (a >> 1);
  endfunction

  function automatic logic [WIDTH-1:0] sub_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    return (a >= b) ? a - b : a + (m - b);
  endfunction

  assign terminal = (u_reg == ONE) || (v_reg == ONE) || (u_reg == '0) || (v_reg == '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= INV_IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      INV_IDLE: if (go) state_next = INV_RUN;
      INV_RUN:  if (terminal) state_next = INV_IDLE;
      default:  state_next = INV_IDLE;
    endcase
  end

  always_comb begin
    load = (state_reg == INV_IDLE) && go;
    run  = (state_reg == INV_RUN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      u_reg    <= '0;
      v_reg    <= '0;
      x1_reg   <= '0;
      x2_reg   <= '0;
      p_reg    <= '0;
      inv_reg  <= '0;
      done_reg <= 1'b0;
      fail_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (load) begin
        u_reg  <= x;
        v_reg  <= p;
        x1_reg <= ONE;
        x2_reg <= '0;
        p_reg  <= p;
      end else if (run) begin
        if (u_reg == ONE) begin
          inv_reg  <= x1_reg;
          fail_reg <= 1'b0;
          done_reg <= 1'b1;
        end else if (v_reg == ONE) begin
          inv_reg  <= x2_reg;
          fail_reg <= 1'b0;
          done_reg <= 1'b1;
        end else if (u_reg == '0 || v_reg == '0) begin
          // A zero operand means the common divisor never reached 1.
          inv_reg  <= '0;
          fail_reg <= 1'b1;
          done_reg <= 1'b1;
        end else if (!u_reg[0]) begin
          u_reg  <= u_reg >> 1;
          x1_reg <= half_mod(x1_reg, p_reg);
        end else if (!v_reg[0]) begin
          v_reg  <= v_reg >> 1;
          x2_reg <= half_mod(x2_reg, p_reg);
        end else if (u_reg >= v_reg) begin
          u_reg  <= u_reg - v_reg;
          x1_reg <= sub_mod(x1_reg, x2_reg, p_reg);
        end else begin
          v_reg  <= v_reg - u_reg;
          x2_reg <= sub_mod(x2_reg, x1_reg, p_reg);
        end
      end
    end
  end

  assign x_inv   = inv_reg;
  assign done    = done_reg;
  assign failure = fail_reg;

endmodule

// File: rtl/ecc_point_unit.sv
// Affine point doubling / addition on y^2 = x^3 + ax + b over GF(p), with
// infinity handling and a sequential modular inverse for lambda.
module ecc_point_unit
  import ecc_point_unit_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             mode,
  input  logic [WIDTH-1:0] prime,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] Px,
  input  logic [WIDTH-1:0] Py,
  input  logic [WIDTH-1:0] Qx,
  input  logic [WIDTH-1:0] Qy,
  input  logic             infiniteP,
  input  logic             infiniteQ,
  output logic [WIDTH-1:0] Rx,
  output logic [WIDTH-1:0] Ry,
  output logic             infiniteR,
  output logic             busy,
  output logic             done,
  output logic             failure
);

  state_t           state_reg, state_next;
  logic             mode_reg, infp_reg, infq_reg, dbl_reg;
  logic [WIDTH-1:0] p_reg, a_reg, px_reg, py_reg, qx_reg, qy_reg;
  logic [WIDTH-1:0] num_reg, den_reg, inv_reg, lambda_reg;
  logic [WIDTH-1:0] rx_reg, ry_reg;
  logic             infr_reg, fail_reg;

  logic             inv_go, inv_done, inv_fail;
  logic [WIDTH-1:0] inv_x;

  logic             special, spec_inf, use_dbl;
  logic [WIDTH-1:0] spec_rx, spec_ry;
  logic [WIDTH-1:0] sq_px, num_val, den_val, x2_val, lam_sq, rx_val, diff_val, prod_val, ry_val;

  function automatic logic [2*WIDTH-1:0] wd(input logic [WIDTH-1:0] a);
    return {{WIDTH{1'b0}}, a};
  endfunction

  function automatic logic [WIDTH-1:0] red(input logic [2*WIDTH-1:0] v, input logic [WIDTH-1:0] m);
    return WIDTH'(v % wd(m));
  endfunction

  function automatic logic [WIDTH-1:0] mul_mod(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                               input logic [WIDTH-1:0] m);
    return red(wd(a) * wd(b), m);
  endfunction

  mod_inv #(.WIDTH(WIDTH)) u_inv (
    .clk     (clk),
    .rst     (rst),
    .go      (inv_go),
    .x       (den_reg),
    .p       (p_reg),
    .x_inv   (inv_x),
    .done    (inv_done),
    .failure (inv_fail)
  );

  // Special cases resolve without an inverse; P==Q in add mode falls into doubling.
  always_comb begin
    special  = 1'b0;
    spec_inf = 1'b0;
    spec_rx  = '0;
    spec_ry  = '0;
    use_dbl  = (mode_reg == MODE_DBL);
    if (mode_reg == MODE_ADD) begin
      if (infp_reg) begin
        special  = 1'b1;
        spec_rx  = qx_reg;
        spec_ry  = qy_reg;
        spec_inf = infq_reg;
      end else if (infq_reg) begin
        special = 1'b1;
        spec_rx = px_reg;
        spec_ry = py_reg;
      end else if (px_reg == qx_reg) begin
        if (py_reg == qy_reg) begin
          use_dbl = 1'b1;
        end else begin
          special  = 1'b1;
          spec_inf = 1'b1;
        end
      end
    end
    if (use_dbl && (infp_reg || py_reg == '0)) begin
      special  = 1'b1;
      spec_inf = 1'b1;
      spec_rx  = '0;
      spec_ry  = '0;
    end
  end

  always_comb begin
    sq_px    = mul_mod(px_reg, px_reg, p_reg);
    if (use_dbl) begin
      num_val = red(wd(sq_px) + wd(sq_px) + wd(sq_px) + wd(a_reg), p_reg);
      den_val = red(wd(py_reg) + wd(py_reg), p_reg);
    end else begin
      num_val = red(wd(qy_reg) + wd(p_reg) - wd(py_reg), p_reg);
      den_val = red(wd(qx_reg) + wd(p_reg) - wd(px_reg), p_reg);
    end
    x2_val   = dbl_reg ? px_reg : qx_reg;
    lam_sq   = mul_mod(lambda_reg, lambda_reg, p_reg);
    rx_val   = red(wd(lam_sq) + wd(p_reg) + wd(p_reg) - wd(px_reg) - wd(x2_val), p_reg);
    diff_val = red(wd(px_reg) + wd(p_reg) - wd(rx_reg), p_reg);
    prod_val = mul_mod(lambda_reg, diff_val, p_reg);
    ry_val   = red(wd(prod_val) + wd(p_reg) - wd(py_reg), p_reg);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_reg <= IDLE;
    else      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:      if (go) state_next = CLASSIFY;
      CLASSIFY:  state_next = special ? FINISH : INV_START;
      INV_START: state_next = INV_WAIT;
      INV_WAIT:  if (inv_done) state_next = inv_fail ? FINISH : LAMBDA;
      LAMBDA:    state_next = XR;
      XR:        state_next = YR;
      YR:        state_next = FINISH;
      FINISH:    state_next = IDLE;
      default:   state_next = IDLE;
    endcase
  end

  always_comb begin
    busy   = (state_reg != IDLE) && (state_reg != FINISH);
    done   = (state_reg == FINISH);
    inv_go = (state_reg == INV_START);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode_reg   <= 1'b0;
      infp_reg   <= 1'b0;
      infq_reg   <= 1'b0;
      dbl_reg    <= 1'b0;
      p_reg      <= '0;
      a_reg      <= '0;
      px_reg     <= '0;
      py_reg     <= '0;
      qx_reg     <= '0;
      qy_reg     <= '0;
      num_reg    <= '0;
      den_reg    <= '0;
      inv_reg    <= '0;
      lambda_reg <= '0;
      rx_reg     <= '0;
      ry_reg     <= '0;
      infr_reg   <= 1'b0;
      fail_reg   <= 1'b0;
    end else begin
      case (state_reg)
        IDLE: if (go) begin
          mode_reg <= mode;
          p_reg    <= prime;
          a_reg    <= A;
          px_reg   <= Px;
          py_reg   <= Py;
          qx_reg   <= Qx;
          qy_reg   <= Qy;
          infp_reg <= infiniteP;
          infq_reg <= infiniteQ;
        end
        CLASSIFY: begin
          dbl_reg  <= use_dbl;
          num_reg  <= num_val;
          den_reg  <= den_val;
          fail_reg <= 1'b0;
          infr_reg <= spec_inf;
          if (special) begin
            rx_reg <= spec_rx;
            ry_reg <= spec_ry;
          end
        end
        INV_WAIT: if (inv_done) begin
          inv_reg <= inv_x;
          if (inv_fail) begin
            fail_reg <= 1'b1;
            rx_reg   <= '0;
            ry_reg   <= '0;
            infr_reg <= 1'b0;
          end
        end
        LAMBDA: lambda_reg <= mul_mod(num_reg, inv_reg, p_reg);
        XR:     rx_reg     <= rx_val;
        YR:     ry_reg     <= ry_val;
        default: ;
      endcase
    end
  end

  assign Rx        = rx_reg;
  assign Ry        = ry_reg;
  assign infiniteR = infr_reg;
  assign failure   = fail_reg;

endmodule

// File: tb/tb_ecc_point_unit.sv
// Directed bench for ecc_point_unit on small curves (p=17 a=2, p=15) with
// hand-computed point results, latency, reset-abort and go-while-busy cases.
module tb_ecc_point_unit;

  logic        clk, rst, go, mode;
  logic [63:0] prime, A, Px, Py, Qx, Qy;
  logic        infiniteP, infiniteQ;
  logic [63:0] Rx, Ry;
  logic        infiniteR, busy, done, failure;

  int checks = 0;
  int errors = 0;

  ecc_point_unit #(.WIDTH(64)) dut (
    .clk       (clk),
    .rst       (rst),
    .go        (go),
    .mode      (mode),
    .prime     (prime),
    .A         (A),
    .Px        (Px),
    .Py        (Py),
    .Qx        (Qx),
    .Qy        (Qy),
    .infiniteP (infiniteP),
    .infiniteQ (infiniteQ),
    .Rx        (Rx),
    .Ry        (Ry),
    .infiniteR (infiniteR),
    .busy      (busy),
    .done      (done),
    .failure   (failure)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic m, input logic [63:0] p, input logic [63:0] a,
                       input logic [63:0] px, input logic [63:0] py,
                       input logic [63:0] qx, input logic [63:0] qy,
                       input logic ip, input logic iq);
    mode = m; prime = p; A = a; Px = px; Py = py; Qx = qx; Qy = qy;
    infiniteP = ip; infiniteQ = iq;
  endtask

  // Pulse go for one edge; returns just after that edge.
  task automatic start(input logic m, input logic [63:0] p, input logic [63:0] a,
                       input logic [63:0] px, input logic [63:0] py,
                       input logic [63:0] qx, input logic [63:0] qy,
                       input logic ip, input logic iq);
    @(negedge clk);
    drive(m, p, a, px, py, qx, qy, ip, iq);
    go = 1'b1;
    @(posedge clk);
    #1 go = 1'b0;
  endtask

  // Counts falling edges from the go edge until done is seen.
  task automatic wait_done(input string tag, output int cyc);
    cyc = 0;
    while (cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) check({tag, "_busy_first"}, busy, 1);
      if (done) break;
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_busy_at_done"}, busy, 0);
  endtask

  task automatic finish_checks(input string tag, input int cyc,
                               input logic [63:0] erx, input logic [63:0] ery,
                               input logic einf, input logic efail, input int ecyc);
    $display("op %s: Rx=%0d Ry=%0d infR=%0b failure=%0b cycles=%0d", tag, Rx, Ry, infiniteR, failure, cyc);
    check({tag, "_Rx"}, Rx, erx);
    check({tag, "_Ry"}, Ry, ery);
    check({tag, "_infR"}, infiniteR, einf);
    check({tag, "_failure"}, failure, efail);
    if (ecyc > 0) check({tag, "_latency"}, cyc, ecyc);
    @(negedge clk);
    check({tag, "_done_single"}, done, 0);
    check({tag, "_Rx_hold"}, Rx, erx);
  endtask

  task automatic do_op(input string tag, input logic m, input logic [63:0] p, input logic [63:0] a,
                       input logic [63:0] px, input logic [63:0] py,
                       input logic [63:0] qx, input logic [63:0] qy,
                       input logic ip, input logic iq,
                       input logic [63:0] erx, input logic [63:0] ery,
                       input logic einf, input logic efail, input int ecyc);
    int cyc;
    start(m, p, a, px, py, qx, qy, ip, iq);
    wait_done(tag, cyc);
    finish_checks(tag, cyc, erx, ery, einf, efail, ecyc);
  endtask

  initial begin
    int cyc;
    int done_cnt;
    rst = 1'b0;
    go  = 1'b0;
    drive(1'b0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0);
    #12;
    check("reset_Rx", Rx, 0);
    check("reset_Ry", Ry, 0);
    check("reset_infR", infiniteR, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_failure", failure, 0);
    @(negedge clk);
    rst = 1'b1;

    // p=17, a=2
    do_op("dbl_5_1",     1'b0, 17, 2, 5, 1, 0, 0,  1'b0, 1'b0, 6, 3, 1'b0, 1'b0, 0);
    do_op("add_5_1_6_3", 1'b1, 17, 2, 5, 1, 6, 3,  1'b0, 1'b0, 10, 6, 1'b0, 1'b0, 0);
    do_op("add_neg",     1'b1, 17, 2, 5, 1, 5, 16, 1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 2);
    do_op("add_infP",    1'b1, 17, 2, 0, 0, 6, 3,  1'b1, 1'b0, 6, 3, 1'b0, 1'b0, 2);
    do_op("add_infQ",    1'b1, 17, 2, 5, 1, 0, 0,  1'b0, 1'b1, 5, 1, 1'b0, 1'b0, 2);
    do_op("dbl_py0",     1'b0, 17, 2, 3, 0, 0, 0,  1'b0, 1'b0, 0, 0, 1'b1, 1'b0, 2);
    do_op("add_same",    1'b1, 17, 2, 5, 1, 5, 1,  1'b0, 1'b0, 6, 3, 1'b0, 1'b0, 0);
    // p=15: den = 6 shares factor 3 with p
    do_op("dbl_noinv",   1'b0, 15, 2, 1, 3, 0, 0,  1'b0, 1'b0, 0, 0, 1'b0, 1'b1, 0);

    // Establish a nonzero result, then abort a doubling inside INV_WAIT.
    do_op("dbl_pre_rst", 1'b0, 17, 2, 5, 1, 0, 0,  1'b0, 1'b0, 6, 3, 1'b0, 1'b0, 0);
    start(1'b0, 17, 2, 5, 1, 0, 0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check("abort_busy_before", busy, 1);
    rst = 1'b0;
    #1;
    $display("op abort: Rx=%0d Ry=%0d busy=%0b done=%0b", Rx, Ry, busy, done);
    check("abort_Rx", Rx, 0);
    check("abort_Ry", Ry, 0);
    check("abort_busy", busy, 0);
    check("abort_done", done, 0);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    done_cnt = 0;
    repeat (20) begin
      @(negedge clk);
      if (done) done_cnt++;
    end
    check("abort_no_done", done_cnt, 0);
    do_op("dbl_post_rst", 1'b0, 17, 2, 5, 1, 0, 0, 1'b0, 1'b0, 6, 3, 1'b0, 1'b0, 0);

    // Second go with different operands while busy must be ignored.
    start(1'b0, 17, 2, 5, 1, 0, 0, 1'b0, 1'b0);
    @(negedge clk);
    drive(1'b1, 17, 2, 6, 3, 10, 6, 1'b0, 1'b0);
    go = 1'b1;
    @(negedge clk);
    go = 1'b0;
    cyc = 2;
    while (cyc < 3000 && !done) begin
      @(negedge clk);
      cyc++;
    end
    check("ignore_done_seen", done, 1);
    finish_checks("ignore_go", cyc, 6, 3, 1'b0, 1'b0, 0);
    check("ignore_idle_busy", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ecc_point_unit.md
ECC_POINT_UNIT -- requirements
Module: ecc_point_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 64, the bit width of the prime, coordinates and curve coefficient.
REQ-002 SHALL have port clk  input  1  the single clock; every register SHALL be clocked on its rising edge.
REQ-003 SHALL have port rst  input  1  reset, asynchronous and active-low: asserted at rst=0.
REQ-004 SHALL have port go  input  1  start request, sampled only in IDLE.
REQ-005 SHALL have port mode  input  1  operation select: 0 = double P; 1 = add P+Q.
REQ-006 SHALL have ports prime, A  input  WIDTH  field modulus p (odd) and curve coefficient a of y^2 = x^3 + ax + b.
REQ-007 SHALL have ports Px, Py, Qx, Qy  input  WIDTH  operand coordinates, each in [0, p-1].
REQ-008 SHALL have ports infiniteP, infiniteQ  input  1  flag that the operand is the point at infinity.
REQ-009 SHALL have ports Rx, Ry  output  WIDTH  result coordinates; infiniteR  output  1  result is infinity.
REQ-010 SHALL have ports busy  output  1  operation in progress; done  output  1  one-cycle completion pulse; failure  output  1  denominator not invertible.

Function
REQ-011 SHALL latch mode, prime, A, P, Q and infinity flags on the edge where go=1 in IDLE; go while busy SHALL be ignored.
REQ-012 SHALL use FSM states IDLE, CLASSIFY, INV_START, INV_WAIT, LAMBDA, XR, YR, FINISH.
REQ-013 SHALL classify in CLASSIFY; mode=1 with Px==Qx and Py==Qy SHALL be treated as doubling.
REQ-014 Special cases SHALL bypass the inverse: add with infiniteP -> R=Q; add with infiniteQ -> R=P; add with Px==Qx and Py!=Qy -> infiniteR=1; double with infiniteP or Py==0 -> infiniteR=1.
REQ-015 Special-case results SHALL appear with done=1 exactly 2 cycles after the go edge (CLASSIFY -> FINISH).
REQ-016 The denominator SHALL be (Qx-Px) mod p for add and (2*Py) mod p for double; the numerator SHALL be (Qy-Py) mod p for add and (3*Px^2 + A) mod p for double.
REQ-017 SHALL compute lambda = num * den^-1 mod p in LAMBDA, Rx = (lambda^2 - Px - X2) mod p in XR (X2 = Qx for add, Px for double), and Ry = (lambda*(Px - Rx) - Py) mod p in YR.
REQ-018 All products SHALL use 2*WIDTH-bit intermediates; subtractions SHALL add p before reducing, so no result is ever negative or >= p.
REQ-019 On the regular path, done SHALL pulse 4 cycles after the inverter's done is sampled (LAMBDA, XR, YR, FINISH).
REQ-020 If the inverter reports failure, SHALL go to FINISH with failure=1, Rx=Ry=0, infiniteR=0.
REQ-021 Rx, Ry, infiniteR and failure SHALL hold their values from FINISH until the next accepted go; busy SHALL be 1 from the cycle after go until the cycle done is asserted.
REQ-022 done SHALL be high for exactly one cycle; busy and done SHALL never both be 1.

Reset
REQ-023 With rst=0, SHALL immediately force the FSM to IDLE and clear Rx, Ry, infiniteR, busy, done, failure and all latched operands to 0.
REQ-024 Reset mid-operation SHALL also reset the inverter; no done pulse SHALL follow the aborted operation.

Structure
REQ-025 A shared package SHALL hold the FSM state enum and the mode encodings (MODE_DBL=0, MODE_ADD=1).
REQ-026 The modular inverse SHALL be one sub-module, mod_inv (binary extended Euclid, parameter WIDTH, ports clk/rst/go/x/p/x_inv/done/failure), started for one cycle in INV_START.

Verification
REQ-027 Curve a=2, p=17, mode=0, P=(5,1) -> done with R=(6,3), infiniteR=0, failure=0.
REQ-028 Same curve, mode=1, P=(5,1), Q=(6,3) -> R=(10,6); then P=(5,1), Q=(5,16) -> infiniteR=1, done 2 cycles after go.
REQ-029 mode=1, infiniteP=1, Q=(6,3) -> R=(6,3), infiniteR=0, done 2 cycles after go; mode=0, Py=0 -> infiniteR=1.
REQ-030 p=15, mode=0, P=(1,3) (den=6, gcd 3) -> failure=1, Rx=Ry=0, single done pulse.
REQ-031 Assert rst=0 while in INV_WAIT during a (5,1) double -> outputs 0 immediately, no done; after release, a new go completes with R=(6,3).
REQ-032 Pulse go again while busy with different operands -> ignored; the result matches the first operands.
